button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 59 +++++
 tb/tb_button_conditioner.sv | 125 ++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce, edge-detect and latch press flags for raw button pads (BTN_ACTIVE_LOW_EN inverts pads)
module button_conditioner #(
  parameter int N_BUTTONS    = 12,
  parameter int TICK_DIV     = 25000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  input  logic [N_BUTTONS-1:0] clear_i,
  output logic [N_BUTTONS-1:0] level_o,
  output logic [N_BUTTONS-1:0] pressed_o,
  output logic [N_BUTTONS-1:0] released_o,
  output logic [N_BUTTONS-1:0] sticky_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);
  localparam logic [2:0] LAST = 3'(STABLE_TICKS - 1);
  logic [N_BUTTONS-1:0] raw, sync1, sync2;
  logic [PW-1:0] div;
  logic tick;
  logic [2:0] cnt [N_BUTTONS];
`ifdef BTN_ACTIVE_LOW_EN
  assign raw = ~buttons_raw;
`else
  assign raw = buttons_raw;
`endif
  assign tick = div == TOP;
  // two-flop synchronizer; idle (not pressed) after reset
  always_ff @(posedge clk)
    {sync2, sync1} <= reset ? '0 : {sync1, raw};
  // sample-tick prescaler wrapping at TICK_DIV-1
  always_ff @(posedge clk)
    div <= (reset || tick) ? '0 : div + 1'b1;
  // per-channel debounce; pulses land with the first cycle of the new level
  always_ff @(posedge clk) begin
    if (reset) begin
      level_o    <= '0;
      pressed_o  <= '0;
      released_o <= '0;
      for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      pressed_o  <= '0;
      released_o <= '0;
      if (tick)
        for (int i = 0; i < N_BUTTONS; i++)
          if (sync2[i] == level_o[i]) cnt[i] <= '0;
          else if (cnt[i] == LAST) begin
            cnt[i]        <= '0;
            level_o[i]    <= sync2[i];
            pressed_o[i]  <= sync2[i];
            released_o[i] <= ~sync2[i];
          end else cnt[i] <= cnt[i] + 3'd1;
    end
  end
  // sticky press flags; a press pulse beats a simultaneous clear
  always_ff @(posedge clk)
    sticky_o <= reset ? '0 : (sticky_o & ~clear_i) | pressed_o;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized scoreboard bench against a tick-sampling reference model
module tb_button_conditioner;
  localparam int N = 12, TD = 4, S = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] buttons_raw = '0, clear_i = '0;
  logic [N-1:0] level_o, pressed_o, released_o, sticky_o;
  logic [N-1:0] m_lvl, m_prs, m_rel, m_stk, h0, h1;
  int n, run[N];
  logic [4*N-1:0] exp_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  button_conditioner #(.N_BUTTONS(N), .TICK_DIV(TD), .STABLE_TICKS(S)) dut (
    .clk(clk), .reset(reset), .buttons_raw(buttons_raw), .clear_i(clear_i),
    .level_o(level_o), .pressed_o(pressed_o), .released_o(released_o), .sticky_o(sticky_o)
  );
  function automatic logic [N-1:0] pad(input logic [N-1:0] press);
`ifdef BTN_ACTIVE_LOW_EN
    return ~press;
`else
    return press;
`endif
  endfunction
  // one clock: drive inputs at negedge (press is logical "pressed" mask), predict the state after the coming edge
  task automatic step(input logic r, input logic [N-1:0] press, input logic [N-1:0] clr);
    logic [N-1:0] s, nl, np, nr;
    @(negedge clk);
    reset = r;
    buttons_raw = pad(press);
    clear_i = clr;
    if (r) begin
      {m_lvl, m_prs, m_rel, m_stk, h0, h1} = '0;
      n = 0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      s = h1;
      nl = m_lvl;
      np = '0;
      nr = '0;
      if (n % TD == TD - 1)
        for (int i = 0; i < N; i++)
          if (s[i] != m_lvl[i]) begin
            run[i]++;
            if (run[i] == S) begin
              run[i] = 0;
              nl[i] = s[i];
              np[i] = s[i];
              nr[i] = ~s[i];
            end
          end else run[i] = 0;
      m_stk = (m_stk & ~clr) | m_prs;
      m_lvl = nl;
      m_prs = np;
      m_rel = nr;
      h1 = h0;
      h0 = press;
      n++;
    end
    exp_q.push_back({m_lvl, m_prs, m_rel, m_stk});
  endtask
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // monitor: every edge the DUT presents a new output word; compare against the oldest prediction
  initial forever begin
    logic [4*N-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("level", level_o, e[4*N-1:3*N]);
      chk("pressed", pressed_o, e[3*N-1:2*N]);
      chk("released", released_o, e[2*N-1:N]);
      chk("sticky", sticky_o, e[N-1:0]);
    end
  end
  initial begin
    logic [N-1:0] cur, c;
    bit pend;
    repeat (3) step(1'b1, '0, '0);
    repeat (20) step(1'b0, 12'h001, '0);
    repeat (20) step(1'b0, 12'h000, '0);
    repeat (6) step(1'b0, 12'h020, '0);
    repeat (20) step(1'b0, 12'h000, '0);
    repeat (20) step(1'b0, 12'hFFF, '0);
    repeat (20) step(1'b0, 12'h000, 12'hFFF);
    pend = 1'b0;
    repeat (25) begin
      c = '0;
      if (m_prs[3]) begin
        c[3] = 1'b1;
        pend = 1'b1;
      end else if (pend) begin
        c[3] = 1'b1;
        pend = 1'b0;
      end
      step(1'b0, 12'h008, c);
    end
    repeat (20) step(1'b0, 12'h000, '0);
    repeat (5) step(1'b0, 12'h004, '0);
    repeat (2) step(1'b1, 12'h004, '0);
    repeat (20) step(1'b0, 12'h004, '0);
    repeat (20) step(1'b0, 12'h000, 12'h004);
    cur = '0;
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) step(1'b1, cur, '0);
      cur ^= N'($urandom) & N'($urandom);
      repeat ($urandom_range(1, 16))
        step(1'b0, cur, ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
    end
    repeat (20) step(1'b0, cur, '0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
